// File: rtl/mips_mem_arbiter.sv
// Sequential arbiter granting port 2 of the ideal memory to either the MIPS CPU
// data port or the AXI-Lite debug port, with a wait counter bounding AXI starvation.
module mips_mem_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int MAX_WAIT   = 8
) (
   input  logic                    mips_cpu_clk,
   input  logic                    mips_cpu_reset,
   input  logic                    mips_rst,
   input  logic                    cpu_req_valid,
   input  logic                    cpu_req_wr,
   input  logic [31:0]             cpu_req_addr,
   input  logic [31:0]             cpu_req_wdata,
   output logic                    cpu_req_ready,
   output logic                    cpu_resp_valid,
   output logic [31:0]             cpu_resp_rdata,
   input  logic                    axi_rd,
   input  logic                    axi_wr,
   input  logic [ADDR_WIDTH-3:0]   axi_addr,
   input  logic [31:0]             axi_wdata,
   output logic                    axi_done,
   output logic [31:0]             axi_rdata,
   output logic [ADDR_WIDTH-3:0]   mem_waddr,
   output logic [ADDR_WIDTH-3:0]   mem_raddr,
   output logic                    mem_wren,
   output logic                    mem_rden,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   output logic [1:0]              dbg_state_o
);

   localparam int AW = ADDR_WIDTH - 2;
   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, CPU_ACC, AXI_ACC, RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            wr_q, wr_d;
   logic            cpu_q, cpu_d;
   logic [31:0]     resp_rdata_q, resp_rdata_d;
   logic [31:0]     axi_rdata_q, axi_rdata_d;
   logic            axi_pend, starve;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^{cpu_req_addr[31:ADDR_WIDTH], cpu_req_addr[1:0]};

   assign axi_pend       = axi_rd | axi_wr;
   assign starve         = axi_pend & (wait_q == CW'(MAX_WAIT));
   // Reset is folded in so ready reads 0 while the block is held in reset.
   assign cpu_req_ready  = (state_q == IDLE) & ~mips_rst & ~starve & ~mips_cpu_reset;
   assign cpu_resp_rdata = resp_rdata_q;
   assign axi_rdata      = axi_rdata_q;
   assign dbg_state_o    = state_q;

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      wr_d           = wr_q;
      cpu_d          = cpu_q;
      resp_rdata_d   = resp_rdata_q;
      axi_rdata_d    = axi_rdata_q;
      mem_waddr      = '0;
      mem_raddr      = '0;
      mem_wren       = 1'b0;
      mem_rden       = 1'b0;
      mem_wdata      = '0;
      cpu_resp_valid = 1'b0;
      axi_done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req_valid && cpu_req_ready) begin
               addr_d  = cpu_req_addr[ADDR_WIDTH-1:2];
               wdata_d = cpu_req_wdata;
               wr_d    = cpu_req_wr;
               cpu_d   = 1'b1;
               state_d = CPU_ACC;
               if (axi_pend && wait_q != CW'(MAX_WAIT)) wait_d = wait_q + 1'b1;
            end else if (axi_pend) begin
               addr_d  = axi_addr;
               wdata_d = axi_wdata;
               wr_d    = axi_wr;
               cpu_d   = 1'b0;
               state_d = AXI_ACC;
               wait_d  = '0;
            end
         end
         CPU_ACC, AXI_ACC: begin
            mem_waddr = addr_q;
            mem_raddr = addr_q;
            if (wr_q) begin
               mem_wren  = 1'b1;
               mem_wdata = wdata_q;
            end else begin
               mem_rden = 1'b1;
            end
            // Stores answer with rdata 0; AXI rdata only moves on reads.
            if (state_q == CPU_ACC) resp_rdata_d = wr_q ? 32'h0 : mem_rdata;
            else if (!wr_q)         axi_rdata_d  = mem_rdata;
            state_d = RESP;
         end
         RESP: begin
            cpu_resp_valid = cpu_q;
            axi_done       = ~cpu_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (!axi_pend) wait_d = '0;
   end

   always_ff @(posedge mips_cpu_clk or posedge mips_cpu_reset) begin
      if (mips_cpu_reset) begin
         state_q      <= IDLE;
         wait_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wr_q         <= 1'b0;
         cpu_q        <= 1'b0;
         resp_rdata_q <= '0;
         axi_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
         cpu_q        <= cpu_d;
         resp_rdata_q <= resp_rdata_d;
         axi_rdata_q  <= axi_rdata_d;
      end
   end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Sequential arbiter between the MIPS CPU data port and the AXI-Lite debug port, driving port 2 (Waddr/Raddr2/Wren/Rden2/Wdata/Rdata2) of the ideal memory. It replaces the combinational read/write arbitration in the CPU top level. The CPU side gains a valid/ready handshake. AXI accesses wait instead of receiving 0xFFFFFFFF on contention. A wait counter bounds how long the AXI side can be starved.

## Interface
Parameters:
- ADDR_WIDTH, 11, memory byte-address width; word address is ADDR_WIDTH-2 bits (max 13)
- MAX_WAIT, 8, IDLE cycles a pending AXI request may lose to the CPU before it is forced through (≥1)

Ports:
- mips_cpu_clk  in  1  clock
- mips_cpu_reset  in  1  reset, asynchronous, active-high
- mips_rst  in  1  CPU held in reset (from AXI-Lite IF); CPU requests not accepted while high
- cpu_req_valid  in  1  CPU request valid
- cpu_req_wr  in  1  1 = store, 0 = load
- cpu_req_addr  in  32  byte address; bits [ADDR_WIDTH-1:2] used
- cpu_req_wdata  in  32  store data
- cpu_req_ready  out  1  request accepted when valid & ready
- cpu_resp_valid  out  1  one-cycle completion pulse (loads and stores)
- cpu_resp_rdata  out  32  load data, valid with cpu_resp_valid; 0 for stores
- axi_rd  in  1  AXI read request, level, held until axi_done
- axi_wr  in  1  AXI write request, level, held until axi_done
- axi_addr  in  ADDR_WIDTH-2  AXI word address
- axi_wdata  in  32  AXI write data
- axi_done  out  1  one-cycle completion pulse
- axi_rdata  out  32  last AXI read data, held until the next AXI read completes
- mem_waddr  out  ADDR_WIDTH-2  memory write address
- mem_raddr  out  ADDR_WIDTH-2  memory read address
- mem_wren  out  1  memory write enable
- mem_rden  out  1  memory read enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_raddr

## Operation
- FSM states: IDLE, CPU_ACC, AXI_ACC, RESP.
- axi_pend = axi_rd | axi_wr. starve = axi_pend & (wait_cnt == MAX_WAIT).
- cpu_req_ready = (state==IDLE) & ~mips_rst & ~starve.
- Grant in IDLE, evaluated in this order:
  - cpu_req_valid & cpu_req_ready → latch addr/wr/wdata → CPU_ACC.
  - Else if axi_pend → latch axi_addr/axi_wdata and op → AXI_ACC. axi_wr has precedence over axi_rd when both are high.
  - Else stay in IDLE.
- CPU_ACC / AXI_ACC: drive the latched address on mem_raddr and mem_waddr.
  - Write: mem_wren=1, mem_wdata=latched data.
  - Read: mem_rden=1; capture mem_rdata into the response register (CPU) or axi_rdata (AXI).
  - Next state: RESP.
- RESP: pulse cpu_resp_valid or axi_done for the granted master → IDLE.
- mem_* outputs are 0 outside the ACC states; memory never sees both enables from different masters.
- wait_cnt (width clog2(MAX_WAIT+1)):
  - increments, saturating at MAX_WAIT, on each IDLE cycle where axi_pend and the CPU is granted;
  - clears on AXI grant or when axi_pend is low.
- cpu_resp_rdata keeps its last value outside RESP.

## Timing
- Reset (asynchronous): state=IDLE, wait_cnt=0. All outputs 0: ready, resp_valid, resp_rdata, axi_done, axi_rdata, all mem_*.
- CPU latency: accepted at edge T → memory access in cycle T+1 → cpu_resp_valid in cycle T+2. Next accept is possible at T+3, so throughput is 1 per 3 cycles.
- AXI latency: granted at edge T → axi_done in cycle T+2. axi_rd/axi_wr must drop in the cycle after axi_done. A request still high then is treated as a new request.
- mips_rst rising mid-transaction: the latched CPU access completes and its response pulse is issued. No new CPU accepts occur while mips_rst is high.
- mips_cpu_reset mid-transaction: the access is aborted immediately. No response pulse and no write complete after reset deasserts.
- CPU and AXI requesting in the same IDLE cycle: CPU wins unless starve=1.
- Upper cpu_req_addr bits and byte offset [1:0] are ignored, so addresses wrap modulo 2^(ADDR_WIDTH).

## Test plan
- AXI write then read with mips_rst=1: write 0xDEADBEEF to word 5, then read word 5 → axi_done at T+2 each time; axi_rdata=0xDEADBEEF; cpu_req_ready held 0 throughout.
- CPU store/load with mips_rst=0: store 0x12345678 to byte address 0x20, then load 0x20 → cpu_resp_valid 2 cycles after each accept; load returns 0x12345678; store response rdata=0.
- Contention: cpu_req_valid held high continuously while axi_rd is asserted, MAX_WAIT=8 → exactly 8 CPU grants, then AXI granted; cpu_req_ready=0 during the starve cycle.
- Simultaneous axi_wr=axi_rd=1 → the write completes first with axi_done; the read is serviced as a separate request afterwards.
- mips_rst raised the cycle after a CPU load accept → cpu_resp_valid still pulses with the correct data; subsequent cpu_req_valid is not accepted.
- mips_cpu_reset asserted during CPU_ACC of a store to word 3 → all outputs read 0 immediately; word 3 is unchanged after reset releases; state is IDLE.
